// File: rtl/jtag_gpr_ctrl.sv
// JTAG-side access controller for the GPR file: one command in flight, blocked
// writes retried while the execute stage owns the write port.
module jtag_gpr_ctrl #(
   parameter int MAX_RETRY = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic        cmd_write_i,
   input  logic [4:0]  cmd_addr_i,
   input  logic [31:0] cmd_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
   input  logic        ex_we_i,
   input  logic [4:0]  ex_waddr_i,
   output logic        jtag_we_o,
   output logic [4:0]  jtag_addr_o,
   output logic [31:0] jtag_wdata_o,
   input  logic [31:0] jtag_rdata_i
);

   localparam int CW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t          r_state, w_next;
   logic            r_write;
   logic [4:0]      r_addr;
   logic [31:0]     r_wdata;
   logic [31:0]     r_rdata;
   logic            r_err;
   logic [CW-1:0]   r_cnt;

   logic            w_wr_nz;
   logic            w_blocked;
   logic            w_at_limit;
   logic            w_retry;

   assign w_wr_nz    = r_write & (r_addr != 5'd0);
   assign w_blocked  = ex_we_i & (ex_waddr_i != 5'd0);
   assign w_at_limit = (r_cnt == CW'(MAX_RETRY));
   assign w_retry    = w_wr_nz & w_blocked & ~w_at_limit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      cmd_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      jtag_we_o   = 1'b0;
      case (r_state)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) w_next = ISSUE;
         end
         ISSUE: begin
            jtag_we_o = w_wr_nz;
            if (!w_retry) w_next = RESP;
         end
         RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // Address/data registers double as the jtag_* drivers, so they only move on acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_write <= 1'b0;
         r_addr  <= 5'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid_i) begin
                  r_write <= cmd_write_i;
                  r_addr  <= cmd_addr_i;
                  r_wdata <= cmd_wdata_i;
                  r_cnt   <= '0;
               end
            end
            ISSUE: begin
               if (w_retry) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_rdata <= r_write ? 32'd0 : jtag_rdata_i;
                  r_err   <= w_wr_nz & w_blocked;
               end
            end
            default: ;
         endcase
      end
   end

   assign jtag_addr_o  = r_addr;
   assign jtag_wdata_o = r_wdata;
   assign rsp_rdata_o  = r_rdata;
   assign rsp_err_o    = r_err;

endmodule

// File: tb/tb_jtag_gpr_ctrl.sv
// Bench for jtag_gpr_ctrl: behavioural register file plus a per-command
// reference for attempt count, latency, response and final register content.
module tb_jtag_gpr_ctrl;

   localparam int MR = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [4:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;
   logic        ex_we = 1'b0;
   logic [4:0]  ex_waddr = '0;
   logic [31:0] ex_wdata = '0;
   logic        jtag_we;
   logic [4:0]  jtag_addr;
   logic [31:0] jtag_wdata, jtag_rdata;

   logic [31:0] rf [32];

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   jtag_gpr_ctrl #(.MAX_RETRY(MR)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
      .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
      .ex_we_i(ex_we), .ex_waddr_i(ex_waddr),
      .jtag_we_o(jtag_we), .jtag_addr_o(jtag_addr), .jtag_wdata_o(jtag_wdata),
      .jtag_rdata_i(jtag_rdata)
   );

   // Register file: execute port wins, colliding JTAG write is dropped.
   always @(posedge clk) begin
      if (ex_we && ex_waddr != 5'd0)          rf[ex_waddr] <= ex_wdata;
      else if (jtag_we && jtag_addr != 5'd0)  rf[jtag_addr] <= jtag_wdata;
   end
   assign jtag_rdata = (jtag_addr == 5'd0) ? 32'd0 : rf[jtag_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outs;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_jtag_we", jtag_we, 0);
      chk("rst_jtag_addr", jtag_addr, 0);
      chk("rst_jtag_wdata", jtag_wdata, 0);
   endtask

   // nblk: consecutive ISSUE cycles with ex_we=1 at ex address exa; bp: cycles of rsp_ready=0.
   task automatic do_cmd(input bit wr, input logic [4:0] a, input logic [31:0] d,
                         input int nblk, input int bp, input logic [4:0] exa);
      logic [31:0] old, exp_rd;
      int att, eff;
      bit err;
      old = (a == 5'd0) ? 32'd0 : rf[a];
      eff = (exa == 5'd0) ? 0 : nblk;
      if (wr && a != 5'd0) begin
         if (eff <= MR) begin att = eff + 1; err = 0; end
         else           begin att = MR + 1;  err = 1; end
      end else begin
         att = 1; err = 0;
      end
      exp_rd = wr ? 32'd0 : old;

      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
      tick;
      cmd_valid = 1'b0; cmd_addr = 5'($urandom); cmd_wdata = $urandom;
      chk("jtag_addr", jtag_addr, a);
      chk("jtag_wdata", jtag_wdata, d);
      for (int i = 0; i < att; i++) begin
         ex_we = (i < nblk); ex_waddr = exa; ex_wdata = $urandom;
         chk("jtag_we_issue", jtag_we, (wr && a != 5'd0));
         chk("rsp_valid_issue", rsp_valid, 0);
         chk("cmd_ready_issue", cmd_ready, 0);
         tick;
      end
      ex_we = 1'b0;
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", rsp_err, err);
      chk("jtag_we_resp", jtag_we, 0);
      for (int i = 0; i < bp; i++) begin
         tick;
         chk("bp_rsp_valid", rsp_valid, 1);
         chk("bp_rsp_rdata", rsp_rdata, exp_rd);
         chk("bp_rsp_err", rsp_err, err);
         chk("bp_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      tick;
      rsp_ready = 1'b0;
      chk("rsp_done_valid", rsp_valid, 0);
      chk("rsp_done_ready", cmd_ready, 1);
      if (a != 5'd0) chk("rf_after", rf[a], (wr && !err) ? d : old);
   endtask

   initial begin
      logic [31:0] old6;
      logic [4:0]  ra, rx;
      repeat (2) tick;
      chk_reset_outs();
      rst = 1'b0;

      for (int r = 1; r < 32; r++) begin
         ex_we = 1'b1; ex_waddr = 5'(r);
         ex_wdata = (r == 5) ? 32'h1234_5678 : $urandom;
         tick;
      end
      ex_we = 1'b0;
      tick;

      do_cmd(0, 5'd5,  32'h0,         0, 0, 5'd0);
      do_cmd(1, 5'd10, 32'hDEAD_BEEF, 0, 0, 5'd0);
      do_cmd(0, 5'd10, 32'h0,         0, 0, 5'd0);
      chk("rd10_back", rsp_rdata, 32'hDEAD_BEEF);
      do_cmd(1, 5'd3,  32'hA5A5_A5A5, 3, 0, 5'd7);
      do_cmd(1, 5'd4,  32'h0000_0001, 16, 0, 5'd1);
      do_cmd(1, 5'd8,  32'h8888_0015, 15, 1, 5'd2);
      do_cmd(1, 5'd9,  32'h0909_0909, 4, 0, 5'd0);
      do_cmd(1, 5'd0,  32'hFFFF_FFFF, 0, 5, 5'd0);
      do_cmd(0, 5'd0,  32'h0,         0, 2, 5'd0);
      do_cmd(0, 5'd5,  32'h0,         0, 0, 5'd0);

      old6 = rf[6];
      chk("cmd_ready_pre_rst", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd6; cmd_wdata = 32'hCAFE_F00D;
      tick;
      cmd_valid = 1'b0;
      ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = $urandom;
      tick;
      chk("retry_we", jtag_we, 1);
      #2 rst = 1'b1;
      #1 chk_reset_outs();
      ex_we = 1'b0;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk("post_rst_we", jtag_we, 0);
         chk("post_rst_valid", rsp_valid, 0);
      end
      chk("rf6_untouched", rf[6], old6);
      do_cmd(1, 5'd6, 32'h0606_0606, 1, 0, 5'd11);

      for (int n = 0; n < 40; n++) begin
         ra = 5'($urandom_range(0, 31));
         do rx = 5'($urandom_range(0, 31)); while (rx == ra && ra != 5'd0);
         do_cmd($urandom_range(0, 1) == 1, ra, $urandom,
                ($urandom_range(0, 7) == 0) ? $urandom_range(15, 18) : $urandom_range(0, 3),
                $urandom_range(0, 3), rx);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
